keycode_decoder: RTL and testbench
==================================

KEYCODE_DECODER -- requirements
Module: keycode_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 5000, meaning the maximum Clk cycles allowed between PS/2 falling edges inside one frame.
REQ-002 SHALL have port Clk, input, 1 bit: system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port Reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port ps2_clk, input, 1 bit: keyboard clock, asynchronous to Clk.
REQ-005 SHALL have port ps2_data, input, 1 bit: keyboard data, asynchronous to Clk.
REQ-006 SHALL have port keycode, output, 8 bits: HID usage code of the held key, or 0x00 when no mapped key is held.
REQ-007 SHALL have port key_valid, output, 1 bit: one-cycle pulse when keycode takes a new nonzero value.
REQ-008 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is rejected.

Function
REQ-009 SHALL pass ps2_clk and ps2_data through a two-flop synchronizer each.
REQ-010 SHALL detect an edge in the cycle where synchronized ps2_clk is 0 and its previous registered value is 1, and sample synchronized ps2_data in that cycle.
REQ-011 SHALL run a bit FSM with states IDLE, DATA, PARITY and STOP.
  - IDLE: on an edge with data 0, go to DATA with bit count 0; on an edge with data 1, stay in IDLE.
  - DATA: shift in 8 bits LSB-first; after the 8th bit, go to PARITY.
  - PARITY: latch the parity bit; go to STOP.
  - STOP: on the edge, check the frame, then return to IDLE.
REQ-012 SHALL accept a frame only if the data plus parity bit have odd parity and the stop bit is 1; an accepted frame raises an internal byte_valid in the cycle after the stop edge.
REQ-013 SHALL reject a frame that fails parity or stop checks: pulse frame_err in the cycle after the stop edge, discard the byte, and return the byte FSM to BASE.
REQ-014 SHALL treat TIMEOUT_CYCLES cycles without an edge while in DATA, PARITY or STOP as a timeout:
  - pulse frame_err;
  - return to IDLE;
  - reset the byte FSM to BASE.
  The counter clears on every edge and is held at 0 in IDLE.
REQ-015 SHALL run a byte FSM with states BASE, EXT, BRK and EXT_BRK.
  - BASE: 0xE0 -> EXT; 0xF0 -> BRK; any other byte is a base make code.
  - EXT: 0xF0 -> EXT_BRK; any other byte is an extended make code, then -> BASE.
  - BRK: the byte is a base break code, then -> BASE.
  - EXT_BRK: the byte is an extended break code, then -> BASE.
REQ-016 SHALL translate base codes 0x1C, 0x1B, 0x23, 0x1D, 0x29 and 0x5A to 0x04, 0x16, 0x07, 0x1A, 0x2C and 0x28, and treat all other base codes as unmapped.
REQ-017 SHALL translate extended codes 0x6B, 0x74, 0x75 and 0x72 to 0x50, 0x4F, 0x52 and 0x51, and treat all other extended codes as unmapped.
REQ-018 SHALL handle a mapped make code by loading keycode with the HID code and pulsing key_valid, both registered one cycle after byte_valid (two cycles after the stop edge).
REQ-019 SHALL pulse key_valid on every mapped make code, including typematic repeats of the same code.
REQ-020 SHALL handle a mapped break code by clearing keycode to 0x00 only if it equals the current keycode; otherwise keycode is unchanged; key_valid is not pulsed.
REQ-021 SHALL ignore unmapped make and break codes, leaving keycode unchanged, while still advancing the byte FSM.
REQ-022 SHALL resolve simultaneous timeout and edge in favour of the edge.
REQ-023 SHALL hold keycode stable between updates, free of glitches, for a frame_clk-domain consumer.

Reset
REQ-024 SHALL, on a Clk edge with Reset_n=0:
  - set keycode to 0x00 and key_valid and frame_err to 0;
  - put the bit FSM in IDLE and the byte FSM in BASE;
  - clear the shift register, bit count and timeout counter;
  - set synchronizer flops to 1.
REQ-025 SHALL abort any frame in progress when reset is applied mid-frame; the first frame after reset release starts cleanly from IDLE.

Verification
REQ-026 SHALL verify: frame 0x1C with parity 0, stop 1 -> keycode=0x04 and key_valid high for one cycle, two cycles after the stop edge.
REQ-027 SHALL verify: bytes 0x1C, then 0xF0, 0x1C -> keycode returns to 0x00 with no key_valid pulse on the break.
REQ-028 SHALL verify: bytes 0x1C then 0x23, then 0xF0, 0x1C -> keycode=0x07 after the second make and stays 0x07 after the A break.
REQ-029 SHALL verify: bytes 0xE0, 0x75 -> keycode=0x52; then 0xE0, 0xF0, 0x75 -> keycode=0x00.
REQ-030 SHALL verify: frame 0x1C with wrong parity 1 -> frame_err pulses once and keycode is unchanged; a frame stalled 6000 cycles after 4 bits with TIMEOUT_CYCLES=5000 -> frame_err pulses, and the next valid 0x1D frame gives keycode=0x1A.
REQ-031 SHALL verify: Reset_n=0 for one cycle mid-frame while keycode=0x16 -> keycode=0x00 next cycle, and a following 0x1B frame gives keycode=0x16.

Source files
------------

// File: rtl/keycode_decoder.sv
// PS/2 keyboard receiver: synchronizes the keyboard lines, deframes 11-bit
// frames and translates set-2 make/break scancodes into a held HID usage code.
module keycode_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} bit_state_t;
  typedef enum logic [1:0] {BASE, EXT, BRK, EXT_BRK}  byte_state_t;

  bit_state_t    bit_state;
  byte_state_t   byte_state;
  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_prev;
  logic          ps2_edge;
  logic          ps2_bit;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;
  logic          byte_valid;
  logic          ext_sel;
  logic [7:0]    hid_code;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign ps2_edge    = clk_prev & ~clk_sync[1];
  assign ps2_bit     = data_sync[1];
  // An edge landing on the expiry cycle wins over the timeout.
  assign timeout_hit = (bit_state != IDLE) && !ps2_edge && (to_cnt == TO_LAST);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      bit_state  <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_state == IDLE || ps2_edge || timeout_hit) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (timeout_hit) begin
        bit_state <= IDLE;
        frame_err <= 1'b1;
      end else if (ps2_edge) begin
        case (bit_state)
          IDLE: begin
            if (!ps2_bit) begin
              bit_state <= DATA;
              bit_cnt   <= '0;
            end
          end
          DATA: begin
            shift_reg <= {ps2_bit, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) bit_state <= PARITY;
          end
          PARITY: begin
            parity_bit <= ps2_bit;
            bit_state  <= STOP;
          end
          STOP: begin
            if ((^{shift_reg, parity_bit}) && ps2_bit) byte_valid <= 1'b1;
            else                                       frame_err  <= 1'b1;
            bit_state <= IDLE;
          end
          default: bit_state <= IDLE;
        endcase
      end
    end
  end

  // shift_reg keeps the received byte until the next frame's data bits arrive.
  always_comb begin
    ext_sel  = (byte_state == EXT) || (byte_state == EXT_BRK);
    hid_code = '0;
    if (ext_sel) begin
      case (shift_reg)
        8'h6B:   hid_code = 8'h50;
        8'h74:   hid_code = 8'h4F;
        8'h75:   hid_code = 8'h52;
        8'h72:   hid_code = 8'h51;
        default: hid_code = '0;
      endcase
    end else begin
      case (shift_reg)
        8'h1C:   hid_code = 8'h04;
        8'h1B:   hid_code = 8'h16;
        8'h23:   hid_code = 8'h07;
        8'h1D:   hid_code = 8'h1A;
        8'h29:   hid_code = 8'h2C;
        8'h5A:   hid_code = 8'h28;
        default: hid_code = '0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      byte_state <= BASE;
      keycode    <= '0;
      key_valid  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_err) begin
        byte_state <= BASE;
      end else if (byte_valid) begin
        case (byte_state)
          BASE: begin
            if (shift_reg == 8'hE0) begin
              byte_state <= EXT;
            end else if (shift_reg == 8'hF0) begin
              byte_state <= BRK;
            end else if (hid_code != '0) begin
              keycode   <= hid_code;
              key_valid <= 1'b1;
            end
          end
          EXT: begin
            if (shift_reg == 8'hF0) begin
              byte_state <= EXT_BRK;
            end else begin
              if (hid_code != '0) begin
                keycode   <= hid_code;
                key_valid <= 1'b1;
              end
              byte_state <= BASE;
            end
          end
          BRK, EXT_BRK: begin
            if (hid_code != '0 && hid_code == keycode) keycode <= '0;
            byte_state <= BASE;
          end
          default: byte_state <= BASE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keycode_decoder.sv
// Bench for keycode_decoder: PS/2 frames driven from tables and $urandom,
// outputs compared every cycle against a scancode-level reference model.
module tb_keycode_decoder;

  localparam int T = 5000;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       key_valid;
  logic       frame_err;

  keycode_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  int       vectors    = 0;
  int       miscompares = 0;
  bit       checking   = 1'b0;
  int       last_fall  = 0;

  // Reference model: scancode tables, prefix flags and timed expectations.
  bit [7:0] base_map[int];
  bit [7:0] ext_map[int];
  bit       ext_pend   = 1'b0;
  bit       brk_pend   = 1'b0;
  bit [7:0] mdl_cur    = 8'h00;
  bit [7:0] mdl_kc     = 8'h00;
  bit       kv_due[int];
  bit       fe_due[int];
  bit [7:0] kc_at[int];

  bit [7:0] pool [14] = '{8'h1C, 8'h1B, 8'h23, 8'h1D, 8'h29, 8'h5A, 8'h6B,
                          8'h74, 8'h75, 8'h72, 8'hE0, 8'hF0, 8'hF0, 8'hE0};

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (checking) begin
      if (kc_at.exists(cyc)) mdl_kc = kc_at[cyc];
      check("keycode",   keycode,               mdl_kc);
      check("key_valid", {7'b0, key_valid},     kv_due.exists(cyc) ? 8'h01 : 8'h00);
      check("frame_err", {7'b0, frame_err},     fe_due.exists(cyc) ? 8'h01 : 8'h00);
    end
  end

  function automatic bit [7:0] hid_of(input bit ext, input bit [7:0] b);
    if (ext) return ext_map.exists(int'(b)) ? ext_map[int'(b)] : 8'h00;
    return base_map.exists(int'(b)) ? base_map[int'(b)] : 8'h00;
  endfunction

  // c is the cycle of the stop-bit fall: two sync stages plus one for the
  // frame check, then one more for the keycode register.
  task automatic model_byte(input bit [7:0] b, input bit ok, input int c);
    bit [7:0] h;
    if (!ok) begin
      fe_due[c+3] = 1'b1;
      ext_pend = 1'b0;
      brk_pend = 1'b0;
      return;
    end
    if (brk_pend) begin
      h = hid_of(ext_pend, b);
      if (h != 8'h00 && h == mdl_cur) begin
        mdl_cur = 8'h00;
        kc_at[c+4] = 8'h00;
      end
      ext_pend = 1'b0;
      brk_pend = 1'b0;
    end else if (b == 8'hF0) begin
      brk_pend = 1'b1;
    end else if (!ext_pend && b == 8'hE0) begin
      ext_pend = 1'b1;
    end else begin
      h = hid_of(ext_pend, b);
      if (h != 8'h00) begin
        mdl_cur = h;
        kc_at[c+4] = h;
        kv_due[c+4] = 1'b1;
      end
      ext_pend = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_frame(input bit [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int gap_idx, input int gap_len);
    bit [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      wait_cyc($urandom_range(3, 6));
      if (i == gap_idx) while (cyc - last_fall < gap_len) wait_cyc(1);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      if (i == 10) model_byte(b, !bad_par && !bad_stop, last_fall);
      wait_cyc((i == 10) ? 3 : $urandom_range(3, 5));
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input bit [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11, -1, 0);
    wait_cyc(6);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) wait_cyc(1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit [7:0] b;
    int       r;
    int       tgt;
    base_map[8'h1C] = 8'h04; base_map[8'h1B] = 8'h16; base_map[8'h23] = 8'h07;
    base_map[8'h1D] = 8'h1A; base_map[8'h29] = 8'h2C; base_map[8'h5A] = 8'h28;
    ext_map[8'h6B]  = 8'h50; ext_map[8'h74]  = 8'h4F; ext_map[8'h75]  = 8'h52;
    ext_map[8'h72]  = 8'h51;

    Reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    checking = 1'b1;
    wait_cyc(1);
    check("rst_keycode", keycode, 8'h00);
    check("rst_frame_err", {7'b0, frame_err}, 8'h00);
    Reset_n = 1'b1;
    wait_cyc(5);

    // Single make: key_valid exactly two cycles after the stop edge
    send_frame(8'h1C, 1'b0, 1'b0, 11, -1, 0);
    wait_until(last_fall + 4);
    check("make_1C_kc", keycode, 8'h04);
    check("make_1C_kv", {7'b0, key_valid}, 8'h01);
    wait_cyc(1);
    check("make_1C_kv_off", {7'b0, key_valid}, 8'h00);
    wait_cyc(5);

    send_byte(8'hF0); send_byte(8'h1C);
    check("break_1C", keycode, 8'h00);

    send_byte(8'h1C); send_byte(8'h23);
    check("make_23", keycode, 8'h07);
    send_byte(8'hF0); send_byte(8'h1C);
    check("stale_break", keycode, 8'h07);
    send_byte(8'hF0); send_byte(8'h23);
    check("break_23", keycode, 8'h00);

    send_byte(8'hE0); send_byte(8'h75);
    check("ext_make_75", keycode, 8'h52);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("ext_break_75", keycode, 8'h00);

    // Typematic repeat pulses key_valid again (checked by the per-cycle model)
    send_byte(8'h1D); send_byte(8'h1D);
    check("repeat_1D", keycode, 8'h1A);

    send_frame(8'h1C, 1'b1, 1'b0, 11, -1, 0);
    wait_until(last_fall + 3);
    check("parity_err_fe", {7'b0, frame_err}, 8'h01);
    wait_cyc(6);
    check("parity_err_kc", keycode, 8'h1A);
    send_frame(8'h5A, 1'b0, 1'b1, 11, -1, 0);
    wait_cyc(6);
    check("stop_err_kc", keycode, 8'h1A);

    // A prefix followed by a bad frame is forgotten
    send_byte(8'hF0);
    send_frame(8'h11, 1'b1, 1'b0, 11, -1, 0);
    wait_cyc(6);
    send_byte(8'h29);
    check("err_clears_prefix", keycode, 8'h2C);

    // Stall after four bits: timeout fires TIMEOUT_CYCLES after the last edge
    send_frame(8'h1C, 1'b0, 1'b0, 4, -1, 0);
    tgt = last_fall + 3 + T;
    fe_due[tgt] = 1'b1;
    ext_pend = 1'b0;
    brk_pend = 1'b0;
    wait_until(tgt);
    check("timeout_fe", {7'b0, frame_err}, 8'h01);
    wait_until(last_fall + 6000);
    send_byte(8'h1D);
    check("after_timeout", keycode, 8'h1A);

    // Edge arriving exactly at expiry keeps the frame alive
    send_frame(8'h29, 1'b0, 1'b0, 11, 5, T);
    wait_cyc(6);
    check("edge_at_expiry", keycode, 8'h2C);

    send_byte(8'h1B);
    check("pre_reset_kc", keycode, 8'h16);
    send_frame(8'h29, 1'b0, 1'b0, 3, -1, 0);
    wait_cyc(2);
    Reset_n  = 1'b0;
    ps2_data = 1'b1;
    kc_at[cyc+1] = 8'h00;
    mdl_cur  = 8'h00;
    ext_pend = 1'b0;
    brk_pend = 1'b0;
    wait_cyc(1);
    Reset_n = 1'b1;
    check("mid_frame_reset_kc", keycode, 8'h00);
    wait_cyc(4);
    send_byte(8'h1B);
    check("post_reset_1B", keycode, 8'h16);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 15);
      if (r < 14) b = pool[r];
      else        b = 8'($urandom);
      send_frame(b, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 4, 11, -1, 0);
      wait_cyc($urandom_range(3, 12));
    end

    wait_cyc(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
